// File: rtl/fetch_responder_if.sv
// Instruction-fetch bundle between the control unit, the fetch responder and program memory.
// The slave modport is the responder's view; master is the control-unit / memory side.
interface fetch_responder_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  fetch_req;
  logic                  fetch_kind;
  logic                  jump_en;
  logic [ADDR_WIDTH-1:0] jump_addr;
  logic                  halt;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rd;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [ADDR_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] instruction;
  logic [DATA_WIDTH-1:0] operand;
  logic                  fetch_done;
  logic                  busy;
  logic                  halted;

  modport slave (
    input  fetch_req, fetch_kind, jump_en, jump_addr, halt, mem_rdata,
    output mem_addr, mem_rd, pc, instruction, operand, fetch_done, busy, halted
  );

  modport master (
    output fetch_req, fetch_kind, jump_en, jump_addr, halt, mem_rdata,
    input  mem_addr, mem_rd, pc, instruction, operand, fetch_done, busy, halted
  );
endinterface

// File: rtl/fetch_responder.sv
// Fetch responder: owns the PC, issues program-memory reads with a fixed wait,
// returns opcode/operand bytes, applies jumps in IDLE and latches halt.
module fetch_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_CYCLES = 1,
  parameter int RESET_PC    = 0
) (
  input  logic            clk,
  input  logic            reset,
  fetch_responder_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    WAIT   = 3'd2,
    DONE   = 3'd3,
    HALTED = 3'd4
  } state_t;

  // Counter only ever holds WAIT_CYCLES-1, so size it for that.
  localparam int CW = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0]         WAIT_LOAD = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [ADDR_WIDTH-1:0] PC_INIT   = ADDR_WIDTH'(RESET_PC);

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
  logic [DATA_WIDTH-1:0] instr_reg, instr_next;
  logic [DATA_WIDTH-1:0] operand_reg, operand_next;
  logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
  logic                  mem_rd_reg, mem_rd_next;
  logic                  fetch_done_reg, fetch_done_next;
  logic                  kind_reg, kind_next;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic                  halt_pend_reg, halt_pend_next;
  logic                  capture;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      pc_reg         <= PC_INIT;
      instr_reg      <= '0;
      operand_reg    <= '0;
      mem_addr_reg   <= '0;
      mem_rd_reg     <= 1'b0;
      fetch_done_reg <= 1'b0;
      kind_reg       <= 1'b0;
      cnt_reg        <= '0;
      halt_pend_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      instr_reg      <= instr_next;
      operand_reg    <= operand_next;
      mem_addr_reg   <= mem_addr_next;
      mem_rd_reg     <= mem_rd_next;
      fetch_done_reg <= fetch_done_next;
      kind_reg       <= kind_next;
      cnt_reg        <= cnt_next;
      halt_pend_reg  <= halt_pend_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    instr_next      = instr_reg;
    operand_next    = operand_reg;
    mem_addr_next   = mem_addr_reg;
    mem_rd_next     = mem_rd_reg;
    fetch_done_next = 1'b0;
    kind_next       = kind_reg;
    cnt_next        = cnt_reg;
    halt_pend_next  = halt_pend_reg;
    capture         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.halt) begin
          state_next = HALTED;
        end else if (bus.jump_en) begin
          // A simultaneous fetch_req is left for the next IDLE cycle.
          pc_next = bus.jump_addr;
        end else if (bus.fetch_req) begin
          kind_next     = bus.fetch_kind;
          mem_addr_next = pc_reg;
          mem_rd_next   = 1'b1;
          state_next    = ADDR;
        end
      end
      ADDR: begin
        if (bus.halt) halt_pend_next = 1'b1;
        if (WAIT_CYCLES == 0) begin
          capture = 1'b1;
        end else begin
          cnt_next   = WAIT_LOAD;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (bus.halt) halt_pend_next = 1'b1;
        if (cnt_reg == '0) begin
          capture = 1'b1;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      DONE: begin
        if (halt_pend_reg || bus.halt) begin
          halt_pend_next = 1'b0;
          state_next     = HALTED;
        end else begin
          state_next = IDLE;
        end
      end
      HALTED: begin
        state_next = HALTED;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (capture) begin
      if (kind_reg) operand_next = bus.mem_rdata;
      else          instr_next   = bus.mem_rdata;
      pc_next         = pc_reg + 1'b1;
      mem_rd_next     = 1'b0;
      fetch_done_next = 1'b1;
      state_next      = DONE;
    end
  end

  assign bus.pc          = pc_reg;
  assign bus.instruction = instr_reg;
  assign bus.operand     = operand_reg;
  assign bus.mem_addr    = mem_addr_reg;
  assign bus.mem_rd      = mem_rd_reg;
  assign bus.fetch_done  = fetch_done_reg;
  assign bus.busy        = (state_reg != IDLE) && (state_reg != HALTED);
  assign bus.halted      = (state_reg == HALTED);

endmodule
